// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int TIMER_ID    = 0;
  localparam int CAUSE_W_DEF = 4;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 (timer) outranks everything.
module int_prio_enc #(
  parameter int N    = 5,
  parameter int ID_W = 4
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: timer + NSRC edge-captured sources, fixed priority,
// one request held until ack, then in service until the handler returns.
module int_ctrl
  import int_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int TIMER_W = 32,
  parameter int CAUSE_W = CAUSE_W_DEF  // 2**CAUSE_W must exceed NSRC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC-1:0]    irq_src,
  input  logic [NSRC:0]      irq_en,
  input  logic               cmp_we,
  input  logic [TIMER_W-1:0] cmp_wdata,
  input  logic               int_ack,
  input  logic               returnM,
  output logic               interupt,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic               in_service,
  output logic [TIMER_W-1:0] mtime
);

  logic [NSRC-1:0]    r_src_q;
  logic [NSRC:0]      r_pend;
  logic [TIMER_W-1:0] r_mtime;
  logic [TIMER_W-1:0] r_cmp;
  state_e             r_state;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_int;
  logic               r_insvc;

  state_e             w_state_nx;
  logic [NSRC:0]      w_set;
  logic [NSRC:0]      w_clr;
  logic [NSRC:0]      w_act;
  logic               w_match;
  logic               w_ack;
  logic               w_win_vld;
  logic [CAUSE_W-1:0] w_win_id;

  assign w_match = (r_mtime == r_cmp);
  assign w_ack   = (r_state == REQ) && int_ack;
  assign w_act   = r_pend & irq_en;

  // A compare write beats a coincident match; otherwise set beats clear.
  always_comb begin
    w_set           = '0;
    w_set[NSRC:1]   = irq_src & ~r_src_q;
    w_set[TIMER_ID] = w_match & ~cmp_we;
    w_clr           = '0;
    if (w_ack)  w_clr = (NSRC + 1)'(1) << r_cause;
    if (cmp_we) w_clr[TIMER_ID] = 1'b1;
  end

  int_prio_enc #(
    .N    (NSRC + 1),
    .ID_W (CAUSE_W)
  ) u_enc (
    .i_req   (w_act),
    .o_valid (w_win_vld),
    .o_id    (w_win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q <= '0;
      r_pend  <= '0;
      r_mtime <= '0;
      r_cmp   <= '1;
    end else begin
      r_src_q <= irq_src;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_mtime <= r_mtime + TIMER_W'(1);
      if (cmp_we) r_cmp <= cmp_wdata;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_win_vld) w_state_nx = REQ;
      REQ:     if (int_ack)   w_state_nx = SERVICE;
      SERVICE: if (returnM)   w_state_nx = IDLE;
      default:                w_state_nx = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so nothing reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_int   <= 1'b0;
      r_insvc <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_int   <= (w_state_nx == REQ);
      r_insvc <= (w_state_nx == SERVICE);
      if (r_state == IDLE && w_win_vld) r_cause <= w_win_id;
    end
  end

  assign interupt   = r_int;
  assign irq_cause  = r_cause;
  assign in_service = r_insvc;
  assign mtime      = r_mtime;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a narrow timer so the wrap is reachable.
module tb_int_ctrl;

  localparam int NSRC    = 4;
  localparam int TIMER_W = 12;
  localparam int CAUSE_W = 4;

  logic               clk;
  logic               rst_n;
  logic [NSRC-1:0]    irq_src;
  logic [NSRC:0]      irq_en;
  logic               cmp_we;
  logic [TIMER_W-1:0] cmp_wdata;
  logic               int_ack;
  logic               returnM;
  logic               interupt;
  logic [CAUSE_W-1:0] irq_cause;
  logic               in_service;
  logic [TIMER_W-1:0] mtime;

  int n_chk;
  int n_err;
  logic [TIMER_W-1:0] m_time;

  int_ctrl #(.NSRC(NSRC), .TIMER_W(TIMER_W), .CAUSE_W(CAUSE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src    (irq_src),
    .irq_en     (irq_en),
    .cmp_we     (cmp_we),
    .cmp_wdata  (cmp_wdata),
    .int_ack    (int_ack),
    .returnM    (returnM),
    .interupt   (interupt),
    .irq_cause  (irq_cause),
    .in_service (in_service),
    .mtime      (mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timer: counts edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_time <= '0;
    else        m_time <= m_time + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CAUSE_W-1:0] order [3];
    bit seen;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0; irq_src = '0; irq_en = '1; cmp_we = 1'b0; cmp_wdata = '0;
    int_ack = 1'b0; returnM = 1'b0;

    // Reset state and free-running timer
    tickn(3);
    chk("rst_int",   interupt,   0);
    chk("rst_cause", irq_cause,  0);
    chk("rst_svc",   in_service, 0);
    chk("rst_mtime", mtime,      0);
    rst_n = 1'b1;
    tick();
    chk("mtime_1", mtime, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mtime_cnt", mtime, m_time);
    end

    // Single external pulse: 2-cycle latency, hold through en drop and stray returnM
    irq_src = 4'b0100;
    tick();
    chk("t1_lat_int", interupt, 0);
    irq_src = '0;
    tick();
    chk("t1_int",   interupt,  1);
    chk("t1_cause", irq_cause, 3);
    irq_en = '0; returnM = 1'b1;
    tick();
    returnM = 1'b0; irq_en = '1;
    chk("t1_hold_int",   interupt,  1);
    chk("t1_hold_cause", irq_cause, 3);
    chk("t1_hold_svc",   in_service, 0);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t1_ack_int", interupt,   0);
    chk("t1_ack_svc", in_service, 1);
    tickn(2);
    chk("t1_svc_stay", in_service, 1);
    returnM = 1'b1;
    tick();
    returnM = 1'b0;
    chk("t1_ret_svc", in_service, 0);
    tick();
    chk("t1_ret_idle", interupt, 0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
    chk("t1_stray_ack", in_service | interupt, 0);

    // Timer + two sources in the same edge: served 0, 1, 4
    cmp_we = 1'b1; cmp_wdata = m_time + 1'b1;
    tick();
    cmp_we = 1'b0; irq_src = 4'b1001;
    tick();
    chk("t3_lat_int", interupt, 0);
    tick();
    order[0] = 4'd0; order[1] = 4'd1; order[2] = 4'd4;
    for (int k = 0; k < 3; k++) begin
      chk("t3_req_int",   interupt,  1);
      chk("t3_req_cause", irq_cause, 32'(order[k]));
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("t3_ack_svc", in_service, 1);
      returnM = 1'b1;
      tick();
      returnM = 1'b0;
      chk("t3_ret_int", interupt | in_service, 0);
      tick();
    end
    chk("t3_drained", interupt, 0);

    // Masked source stays pending until enabled
    irq_src = '0;
    tick();
    irq_en = 5'b11101; irq_src = 4'b0001;
    tickn(4);
    chk("t4_masked", interupt, 0);
    irq_en = '1;
    tick();
    chk("t4_int",   interupt,  1);
    chk("t4_cause", irq_cause, 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    returnM = 1'b1;
    tick();
    returnM = 1'b0; irq_src = '0;
    tickn(2);
    chk("t4_done", interupt | in_service, 0);

    // Compare write in the exact match cycle suppresses the timer
    cmp_we = 1'b1; cmp_wdata = m_time + 12'd2;
    tick();
    cmp_we = 1'b0;
    tick();
    cmp_we = 1'b1; cmp_wdata = m_time;
    tick();
    cmp_we = 1'b0;
    tickn(3);
    chk("t5_suppress", interupt, 0);

    // Timer wrap all-ones -> 0 with mtimecmp = 0
    cmp_we = 1'b1; cmp_wdata = '0;
    tick();
    cmp_we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      tick();
      if (interupt) seen = 1'b1;
    end
    chk("t5_wrap_seen",  seen,      1);
    chk("t5_wrap_mtime", mtime,     2);
    chk("t5_wrap_model", mtime,     m_time);
    chk("t5_wrap_cause", irq_cause, 0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    returnM = 1'b1;
    tick();
    returnM = 1'b0;
    tick();

    // Async reset while in REQ, with another event already pending
    irq_src = 4'b0010;
    tickn(2);
    chk("t6_int",   interupt,  1);
    chk("t6_cause", irq_cause, 2);
    irq_src = 4'b0110;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_int",   interupt,  0);
    chk("t6_rst_cause", irq_cause, 0);
    chk("t6_rst_mtime", mtime,     0);
    irq_src = '0;
    tick();
    rst_n = 1'b1;
    tickn(4);
    chk("t6_post_int",   interupt | in_service, 0);
    chk("t6_post_mtime", mtime, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that raises the core's interrupt request into the CSR trap unit. It aggregates one machine timer and NSRC external level sources into edge-captured pending bits, applies a per-source enable mask, and selects one cause by fixed priority. It holds the request until the CSR unit acknowledges the trap, then stays in service until the handler's return retires in MEM. Sits beside the CSR unit: its `interupt` output feeds the trap path, and `Int_sel` and `returnM` come back as ack and return.

## Interface
- NSRC, 4, number of external sources; cause ids 1..NSRC
- TIMER_W, 32, mtime/mtimecmp width
- CAUSE_W, 4, width of irq_cause; must satisfy 2^CAUSE_W > NSRC
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_src  in  NSRC  external requests, synchronous to clk; bit i is cause i+1
- irq_en  in  NSRC+1  enable mask; bit 0 = timer, bit i = cause i
- cmp_we  in  1  write strobe for mtimecmp
- cmp_wdata  in  TIMER_W  new mtimecmp value
- int_ack  in  1  trap taken (CSR unit Int_sel), one-cycle pulse
- returnM  in  1  handler return retired in MEM, one-cycle pulse
- interupt  out  1  interrupt request to CSR unit
- irq_cause  out  CAUSE_W  cause id latched for current request/service (0 = timer)
- in_service  out  1  handler running
- mtime  out  TIMER_W  free-running timer value

## Operation
- Reset values: interupt 0, irq_cause 0, in_service 0, mtime 0, mtimecmp all-ones, pend 0, irq_src history 0, state IDLE.
- External capture: pend[i] sets on a sampled rising edge of irq_src (current 1, previous 0). Because the history register resets to 0, a source held high through reset produces one edge after release.
- Timer: mtime increments every cycle and wraps from all-ones to 0. pend[0] sets in the cycle mtime == mtimecmp.
- mtimecmp write: cmp_we loads cmp_wdata and clears pend[0]. If the write coincides with a match, the write wins and pend[0] stays 0.
- Priority: among pend & irq_en, the lowest index wins; timer outranks all external sources.
- FSM:
  - IDLE -> REQ when (pend & irq_en) != 0; latch the winning id into irq_cause.
  - REQ -> SERVICE on int_ack; clear pend[irq_cause].
  - SERVICE -> IDLE on returnM.
- Outputs: interupt = (state == REQ); in_service = (state == SERVICE).
- No nesting: events arriving during REQ or SERVICE only accumulate in pend.
- A request is never withdrawn. Once in REQ, irq_cause and interupt hold until int_ack, even if irq_en drops.
- Ignored inputs: int_ack outside REQ; returnM outside SERVICE.
- Same-cycle set and clear of one pend bit: set wins, so a new edge is not lost.
- Async reset mid-request or mid-service returns to IDLE immediately and drops all pending bits.

## Timing
- irq_src edge sampled at clock edge k: pend set after edge k, state REQ after edge k+1. interupt is high from k+1, i.e. 2 cycles of latency.
- Timer match at edge k: interupt high after k+1.
- int_ack at edge j: interupt low and in_service high after j.
- returnM at edge m: in_service low after m. If anything is still pending and enabled, interupt rises after m+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package int_pkg holds:
  - state enum {IDLE, REQ, SERVICE}
  - TIMER_ID = 0
  - CAUSE_W default
- Sub-module int_prio_enc: combinational lowest-index-first encoder over NSRC+1 bits, outputs valid and id.

## Test plan
- Reset released with irq_src=0, irq_en=all-ones: all outputs 0, mtime counts 0,1,2,...
- irq_src[2] pulses at edge 10: interupt high after edge 11 with irq_cause=3. int_ack at edge 15 -> interupt 0, in_service 1. returnM at edge 20 -> in_service 0.
- irq_src[0] and irq_src[3] rise together and mtimecmp=mtime+1: cause 0 is served first, then 1, then 4, each re-requested one cycle after its predecessor's returnM.
- irq_en[1]=0 while irq_src[0] rises: no request. Setting irq_en[1]=1 later -> request with irq_cause=1 (pending retained).
- cmp_we with cmp_wdata=mtime in the exact match cycle: no timer interrupt. mtime wrap from all-ones -> 0 with mtimecmp=0: timer interrupt.
- rst_n low while in REQ: interupt drops immediately. After release, state is IDLE and pend is 0.
